// File: rtl/rx_sample_framer_pkg.sv
// Shared constants, header-queue entry layout and small helpers for rx_sample_framer.
package rx_sample_framer_pkg;

  localparam logic [3:0]  CHDR_DATA_TIME     = 4'h2;
  localparam logic [3:0]  CHDR_DATA_TIME_EOB = 4'h3;
  localparam logic [15:0] HDR_TIME_BYTES     = 16'd16;
  localparam logic [15:0] MAX_SAMPS          = 16'd16376;
  localparam logic [15:0] MAXLEN_RESET       = 16'd364;
  localparam logic [7:0]  SET_SID_OFFSET     = 8'd0;
  localparam logic [7:0]  SET_MAXLEN_OFFSET  = 8'd1;

  // One committed packet: everything the output side needs to emit HDR and TIME beats.
  typedef struct packed {
    logic [3:0]  flags;
    logic [11:0] seqnum;
    logic [15:0] len;
    logic [31:0] sid;
    logic [63:0] vtime;
  } hdr_t;

  function automatic logic [15:0] clamp_maxlen(input logic [15:0] v);
    if (v == 16'd0)
      return 16'd1;
    else if (v > MAX_SAMPS)
      return MAX_SAMPS;
    else
      return v;
  endfunction

  // ceil(nsamps/2) with nsamps = (len-16)/4, folded into one subtract and shift.
  function automatic logic [13:0] len_to_lines(input logic [15:0] len);
    return 14'((len - 16'd12) >> 3);
  endfunction

endpackage

// File: rtl/rx_sample_framer_if.sv
// CHDR AXI-stream output bundle of rx_sample_framer.
interface rx_sample_framer_if;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  modport master (output o_tdata, output o_tlast, output o_tvalid, input o_tready);
  modport slave  (input o_tdata, input o_tlast, input o_tvalid, output o_tready);
endinterface

// File: rtl/rx_sample_framer_fifo.sv
// Single-clock FIFO with show-ahead read data and a free-space count.
module rx_sample_framer_fifo #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_wr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_rd,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_empty,
  output logic [AWIDTH:0]   o_space
);
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(1 << AWIDTH);

  logic [WIDTH-1:0]  r_mem [1 << AWIDTH];
  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_count;
  logic              w_wr;
  logic              w_rd;

  assign w_wr    = i_wr & (r_count != DEPTH);
  assign w_rd    = i_rd & (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_space = DEPTH - r_count;

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd)
        r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AWIDTH + 1)'(w_wr) - (AWIDTH + 1)'(w_rd);
    end
  end
endmodule

// File: rtl/rx_sample_framer.sv
// Packs 32-bit RX samples into 64-bit lines and emits timestamped CHDR data packets.
module rx_sample_framer
  import rx_sample_framer_pkg::*;
#(
  parameter logic [7:0]  BASE           = 8'd0,
  parameter int unsigned DATA_FIFO_SIZE = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] vita_time,
  input  logic        run,
  input  logic        strobe,
  input  logic        eob,
  input  logic [31:0] sample,
  output logic        full,
  output logic [11:0] seqnum,
  output logic [31:0] sid,
  rx_sample_framer_if.master chdr
);
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_HDR  = 2'd1;
  localparam logic [1:0]  S_TIME = 2'd2;
  localparam logic [1:0]  S_DATA = 2'd3;
  localparam int unsigned HDR_AW = 4;
  localparam int unsigned HDR_W  = $bits(hdr_t);
  localparam int unsigned DW     = DATA_FIFO_SIZE + 2;

  logic [31:0] r_sid;
  logic [15:0] r_maxlen;
  logic [15:0] w_maxlen;
  logic        w_unused;

  logic [13:0] r_count;
  logic [31:0] r_stage;
  logic [63:0] r_time;
  logic        r_run_d;
  logic [11:0] r_seqnum;
  logic        r_full;

  logic        r_dwr;
  logic [63:0] r_dline;
  logic        r_hpush;
  hdr_t        r_hdr;

  logic        w_acc, w_ovr, w_rfall, w_acc_close, w_close;
  logic [13:0] w_count_inc, w_nsamps;
  logic        w_eobflag;
  logic [63:0] w_pkt_time;
  logic [15:0] w_len;
  logic        w_dwr_new;
  logic [63:0] w_dline_new;

  logic [63:0]               w_d_rdata;
  logic                      w_d_empty;
  logic [DATA_FIFO_SIZE:0]   w_d_space;
  logic                      w_d_rd;
  logic [HDR_W-1:0]          w_hdr_raw;
  hdr_t                      w_hdr_q;
  logic                      w_h_empty;
  logic [HDR_AW:0]           w_h_space;
  logic                      w_h_rd;
  logic [DW-1:0]             w_d_have, w_d_need;
  logic [HDR_AW+1:0]         w_h_have, w_h_need;
  logic                      w_full_nxt;

  logic [1:0]  r_state;
  logic [13:0] r_beat;
  logic [13:0] w_lines;
  logic        w_last_beat;
  logic        w_fire;

  assign w_unused = ^set_data[31:16];
  assign sid      = r_sid;
  assign seqnum   = r_seqnum;
  assign full     = r_full;
  assign w_maxlen = clamp_maxlen(r_maxlen);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sid    <= '0;
      r_maxlen <= MAXLEN_RESET;
    end else if (set_stb) begin
      if (set_addr == BASE + SET_SID_OFFSET)
        r_sid <= set_data;
      if (set_addr == BASE + SET_MAXLEN_OFFSET)
        r_maxlen <= set_data[15:0];
    end
  end

  // Close sources are mutually exclusive: accept and overrun need run high, run-fall needs it low.
  assign w_acc       = strobe & run & ~r_full;
  assign w_ovr       = strobe & run & r_full & (r_count != '0);
  assign w_rfall     = r_run_d & ~run & (r_count != '0);
  assign w_count_inc = r_count + 14'd1;
  assign w_acc_close = w_acc & (eob | ({2'b00, w_count_inc} >= w_maxlen));
  assign w_close     = w_acc_close | w_ovr | w_rfall;
  assign w_nsamps    = w_acc ? w_count_inc : r_count;
  assign w_eobflag   = w_acc ? eob : 1'b1;
  assign w_pkt_time  = (w_acc && (r_count == '0)) ? vita_time : r_time;
  assign w_len       = HDR_TIME_BYTES + {w_nsamps, 2'b00};

  always_comb begin
    w_dwr_new   = 1'b0;
    w_dline_new = '0;
    if (w_acc) begin
      if (r_count[0]) begin
        w_dwr_new   = 1'b1;
        w_dline_new = {r_stage, sample};
      end else if (w_acc_close) begin
        w_dwr_new   = 1'b1;
        w_dline_new = {sample, 32'h0};
      end
    end else if ((w_ovr | w_rfall) & r_count[0]) begin
      w_dwr_new   = 1'b1;
      w_dline_new = {r_stage, 32'h0};
    end
  end

  // Free space is judged after every write already decided, so one more line and header always fit.
  assign w_d_have   = DW'(w_d_space) + DW'(w_d_rd);
  assign w_d_need   = DW'(2) + DW'(r_dwr) + DW'(w_dwr_new);
  assign w_h_have   = (HDR_AW + 2)'(w_h_space) + (HDR_AW + 2)'(w_h_rd);
  assign w_h_need   = (HDR_AW + 2)'(2) + (HDR_AW + 2)'(r_hpush) + (HDR_AW + 2)'(w_close);
  assign w_full_nxt = (w_d_have < w_d_need) | (w_h_have < w_h_need);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_stage  <= '0;
      r_time   <= '0;
      r_run_d  <= 1'b0;
      r_seqnum <= '0;
      r_full   <= 1'b0;
      r_dwr    <= 1'b0;
      r_dline  <= '0;
      r_hpush  <= 1'b0;
      r_hdr    <= '0;
    end else if (clear) begin
      r_count  <= '0;
      r_stage  <= '0;
      r_time   <= '0;
      r_run_d  <= 1'b0;
      r_seqnum <= '0;
      r_full   <= 1'b0;
      r_dwr    <= 1'b0;
      r_dline  <= '0;
      r_hpush  <= 1'b0;
      r_hdr    <= '0;
    end else begin
      r_run_d <= run;
      r_full  <= w_full_nxt;
      r_dwr   <= w_dwr_new;
      r_dline <= w_dline_new;
      r_hpush <= w_close;
      r_hdr   <= '{flags:  (w_eobflag ? CHDR_DATA_TIME_EOB : CHDR_DATA_TIME),
                   seqnum: r_seqnum,
                   len:    w_len,
                   sid:    r_sid,
                   vtime:  w_pkt_time};
      if (w_acc) begin
        if (r_count == '0)
          r_time <= vita_time;
        if (!r_count[0])
          r_stage <= sample;
      end
      if (w_close) begin
        r_count  <= '0;
        r_seqnum <= r_seqnum + 12'd1;
      end else if (w_acc) begin
        r_count <= w_count_inc;
      end
    end
  end

  rx_sample_framer_fifo #(
    .WIDTH  (64),
    .AWIDTH (DATA_FIFO_SIZE)
  ) u_data_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_clear (clear),
    .i_wr    (r_dwr),
    .i_wdata (r_dline),
    .i_rd    (w_d_rd),
    .o_rdata (w_d_rdata),
    .o_empty (w_d_empty),
    .o_space (w_d_space)
  );

  rx_sample_framer_fifo #(
    .WIDTH  (HDR_W),
    .AWIDTH (HDR_AW)
  ) u_hdr_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_clear (clear),
    .i_wr    (r_hpush),
    .i_wdata (r_hdr),
    .i_rd    (w_h_rd),
    .o_rdata (w_hdr_raw),
    .o_empty (w_h_empty),
    .o_space (w_h_space)
  );

  assign w_hdr_q     = w_hdr_raw;
  assign w_lines     = len_to_lines(w_hdr_q.len);
  assign w_last_beat = (r_beat == w_lines - 14'd1);
  assign w_fire      = chdr.o_tvalid & chdr.o_tready;
  assign w_d_rd      = (r_state == S_DATA) & w_fire;
  assign w_h_rd      = (r_state == S_DATA) & w_fire & w_last_beat;

  // Beats come straight from the FIFO heads, which only move on a handshake, so a stall holds them.
  always_comb begin
    chdr.o_tvalid = 1'b0;
    chdr.o_tdata  = '0;
    chdr.o_tlast  = 1'b0;
    case (r_state)
      S_HDR: begin
        chdr.o_tvalid = 1'b1;
        chdr.o_tdata  = {w_hdr_q.flags, w_hdr_q.seqnum, w_hdr_q.len, w_hdr_q.sid};
      end
      S_TIME: begin
        chdr.o_tvalid = 1'b1;
        chdr.o_tdata  = w_hdr_q.vtime;
      end
      S_DATA: begin
        chdr.o_tvalid = ~w_d_empty;
        chdr.o_tdata  = w_d_rdata;
        chdr.o_tlast  = w_last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_h_empty) r_state <= S_HDR;
        S_HDR:  if (w_fire) r_state <= S_TIME;
        S_TIME: begin
          if (w_fire) begin
            r_state <= S_DATA;
            r_beat  <= '0;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            if (w_last_beat)
              r_state <= S_IDLE;
            else
              r_beat <= r_beat + 14'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_sample_framer.sv
// Self-checking bench for rx_sample_framer: a packet model fills a beat scoreboard drained by a monitor.
module tb_rx_sample_framer;
  logic        clk = 1'b0;
  logic        reset, clear, set_stb, run, strobe, eob;
  logic [7:0]  set_addr;
  logic [31:0] set_data, sample;
  logic [63:0] vita_time;
  logic        full;
  logic [11:0] seqnum;
  logic [31:0] sid;

  rx_sample_framer_if chdr ();

  rx_sample_framer #(.BASE(8'd0), .DATA_FIFO_SIZE(9)) dut (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .vita_time(vita_time), .run(run), .strobe(strobe), .eob(eob),
    .sample(sample), .full(full), .seqnum(seqnum), .sid(sid), .chdr(chdr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_errs = 0;

  logic [63:0] exp_data_q[$];
  logic        exp_last_q[$];
  logic [63:0] hdr_log[$];

  int unsigned m_count;
  logic [31:0] m_samps[$];
  logic [63:0] m_time;
  int unsigned m_seq;
  int unsigned m_maxlen;
  logic [31:0] m_sid;

  logic [63:0] mon_e;
  logic        mon_l;
  logic        mon_first = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      mon_first = 1'b1;
    end else if (chdr.o_tvalid && chdr.o_tready) begin
      if (mon_first) hdr_log.push_back(chdr.o_tdata);
      mon_first = chdr.o_tlast;
      checks++;
      if (exp_data_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat got data=%h last=%b want none", chdr.o_tdata, chdr.o_tlast);
      end else begin
        mon_e = exp_data_q.pop_front();
        mon_l = exp_last_q.pop_front();
        if (chdr.o_tdata !== mon_e || chdr.o_tlast !== mon_l) begin
          failures++;
          $display("FAIL beat got data=%h last=%b want data=%h last=%b",
                   chdr.o_tdata, chdr.o_tlast, mon_e, mon_l);
        end
      end
    end
  end

  function automatic int unsigned eff_maxlen(input int unsigned v);
    if (v == 0) return 1;
    if (v > 16376) return 16376;
    return v;
  endfunction

  task automatic model_close(input bit eobf);
    logic [15:0] len;
    len = 16'(16 + 4 * m_count);
    exp_data_q.push_back({(eobf ? 4'h3 : 4'h2), 12'(m_seq), len, m_sid});
    exp_last_q.push_back(1'b0);
    exp_data_q.push_back(m_time);
    exp_last_q.push_back(1'b0);
    for (int i = 0; i < int'(m_count); i += 2) begin
      exp_data_q.push_back({m_samps[i], (i + 1 < int'(m_count)) ? m_samps[i+1] : 32'h0});
      exp_last_q.push_back(i + 2 >= int'(m_count));
    end
    m_seq = (m_seq + 1) % 4096;
    m_count = 0;
    m_samps.delete();
  endtask

  task automatic model_accept(input logic [31:0] s, input bit e, input logic [63:0] t);
    if (m_count == 0) m_time = t;
    m_samps.push_back(s);
    m_count++;
    if (m_count >= eff_maxlen(m_maxlen) || e) model_close(e);
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    strobe = 1'b0; eob = 1'b0; set_stb = 1'b0; clear = 1'b0;
  endtask

  task automatic send(input logic [31:0] s, input bit e);
    int n;
    n = 0;
    @(posedge clk); #1;
    set_stb = 1'b0;
    while (full && n < 200) begin
      strobe = 1'b0; eob = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (full) begin
      stall_errs++;
      strobe = 1'b0;
    end else begin
      strobe = 1'b1; eob = e; sample = s;
      vita_time = {$urandom, $urandom};
      model_accept(s, e, vita_time);
    end
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    strobe = 1'b0; eob = 1'b0;
    set_stb = 1'b1; set_addr = a; set_data = d;
    if (a == 8'd0) m_sid = d;
    if (a == 8'd1) m_maxlen = d[15:0];
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || chdr.o_tvalid) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (exp_data_q.size() == 0) && !chdr.o_tvalid;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", full); end
    checks++; if (seqnum !== 12'd0) begin failures++; $display("FAIL reset_seqnum got=%0d want=0", seqnum); end
    checks++; if (sid !== 32'd0) begin failures++; $display("FAIL reset_sid got=%h want=0", sid); end
    checks++; if (chdr.o_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b want=0", chdr.o_tvalid); end
    checks++; if (chdr.o_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b want=0", chdr.o_tlast); end
    checks++; if (chdr.o_tdata !== 64'd0) begin failures++; $display("FAIL reset_tdata got=%h want=0", chdr.o_tdata); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [63:0] h0, h1;
    write_reg(8'd1, 32'd4);
    write_reg(8'd0, 32'h0001_0002);
    for (int i = 1; i <= 8; i++) send(32'hA000_0000 + 32'(i), i == 8);
    drive_idle();
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_drain got=timeout want=drained"); end
    h0 = (hdr_log.size() > 0) ? hdr_log[0] : 'x;
    h1 = (hdr_log.size() > 1) ? hdr_log[1] : 'x;
    checks++; if (h0 !== 64'h2000_0020_0001_0002) begin failures++; $display("FAIL basic_hdr0 got=%h want=2000002000010002", h0); end
    checks++; if (h1 !== 64'h3001_0020_0001_0002) begin failures++; $display("FAIL basic_hdr1 got=%h want=3001002000010002", h1); end
    checks++; if (seqnum !== 12'd2) begin failures++; $display("FAIL basic_seqnum got=%0d want=2", seqnum); end
  endtask

  task automatic test_short_eob();
    bit ok;
    write_reg(8'd1, 32'd100);
    for (int i = 1; i <= 3; i++) send(32'hB000_0000 + 32'(i), i == 3);
    drive_idle();
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL short_drain got=timeout want=drained"); end
    checks++; if (hdr_log[$] !== 64'h3002_001C_0001_0002) begin failures++; $display("FAIL short_hdr got=%h want=3002001c00010002", hdr_log[$]); end
  endtask

  task automatic test_maxlen_zero();
    bit ok;
    write_reg(8'd1, 32'd0);
    for (int i = 1; i <= 3; i++) send(32'hC000_0000 + 32'(i), 1'b0);
    drive_idle();
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_drain got=timeout want=drained"); end
    checks++; if (seqnum !== 12'd6) begin failures++; $display("FAIL zero_seqnum got=%0d want=6", seqnum); end
    checks++; if (hdr_log[$] !== 64'h2005_0014_0001_0002) begin failures++; $display("FAIL zero_hdr got=%h want=2005001400010002", hdr_log[$]); end
  endtask

  task automatic test_sid_change();
    bit ok;
    write_reg(8'd1, 32'd100);
    send(32'hD000_0001, 1'b0);
    send(32'hD000_0002, 1'b0);
    write_reg(8'd0, 32'hABCD_0001);
    send(32'hD000_0003, 1'b1);
    drive_idle();
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sid_drain got=timeout want=drained"); end
    checks++; if (sid !== 32'hABCD_0001) begin failures++; $display("FAIL sid_reg got=%h want=abcd0001", sid); end
    checks++; if (hdr_log[$] !== 64'h3006_001C_ABCD_0001) begin failures++; $display("FAIL sid_hdr got=%h want=3006001cabcd0001", hdr_log[$]); end
  endtask

  task automatic test_run_fall();
    bit ok;
    for (int i = 1; i <= 5; i++) send(32'hE000_0000 + 32'(i), 1'b0);
    @(posedge clk); #1;
    strobe = 1'b0; run = 1'b0;
    model_close(1'b1);
    @(posedge clk); #1;
    run = 1'b1;
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL runfall_drain got=timeout want=drained"); end
    checks++; if (hdr_log[$] !== 64'h3007_0024_ABCD_0001) begin failures++; $display("FAIL runfall_hdr got=%h want=30070024abcd0001", hdr_log[$]); end
  endtask

  task automatic test_overrun();
    bit ok;
    int n;
    write_reg(8'd1, 32'd2000);
    @(posedge clk); #1;
    set_stb = 1'b0;
    chdr.o_tready = 1'b0;
    n = 0;
    while (n < 1100) begin
      @(posedge clk); #1;
      if (full) break;
      strobe = 1'b1; eob = 1'b0; sample = 32'h5000_0000 + 32'(n);
      vita_time = {$urandom, $urandom};
      model_accept(sample, 1'b0, vita_time);
      n++;
    end
    checks++; if (n !== 1022) begin failures++; $display("FAIL full_threshold got=%0d want=1022 samples", n); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_asserted got=%b want=1", full); end
    strobe = 1'b1; eob = 1'b0; sample = 32'hDEAD_BEEF;
    model_close(1'b1);
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chdr.o_tready = 1'b1;
    wait_drain(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL overrun_drain got=timeout want=drained"); end
    checks++; if (hdr_log[$] !== 64'h3008_1008_ABCD_0001) begin failures++; $display("FAIL overrun_hdr got=%h want=30081008abcd0001", hdr_log[$]); end
    drive_idle();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_released got=%b want=0", full); end
  endtask

  task automatic test_clear();
    bit ok;
    write_reg(8'd1, 32'd100);
    send(32'hF000_0001, 1'b0);
    send(32'hF000_0002, 1'b0);
    @(posedge clk); #1;
    strobe = 1'b0; clear = 1'b1;
    m_count = 0; m_samps.delete(); m_seq = 0;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (seqnum !== 12'd0) begin failures++; $display("FAIL clear_seqnum got=%0d want=0", seqnum); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (chdr.o_tvalid !== 1'b0) begin failures++; $display("FAIL clear_no_output got=%b want=0", chdr.o_tvalid); end
    send(32'hF000_0003, 1'b1);
    drive_idle();
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL clear_drain got=timeout want=drained"); end
    checks++; if (hdr_log[$] !== 64'h3000_0014_ABCD_0001) begin failures++; $display("FAIL clear_hdr got=%h want=30000014abcd0001", hdr_log[$]); end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    write_reg(8'd1, 32'd1);
    @(posedge clk); #1;
    set_stb = 1'b0; clear = 1'b1;
    m_seq = 0;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 1; i <= 4097; i++) begin
      send(32'(i), 1'b0);
      if (i >= 4095) begin
        drive_idle();
        checks++;
        if (seqnum !== 12'(i % 4096)) begin
          failures++;
          $display("FAIL wrap_seqnum_%0d got=%0d want=%0d", i, seqnum, i % 4096);
        end
      end
    end
    drive_idle();
    wait_drain(40000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain got=timeout want=drained"); end
    checks++; if (stall_errs !== 0) begin failures++; $display("FAIL send_stall got=%0d want=0", stall_errs); end
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    int n;
    write_reg(8'd1, 32'd100);
    @(posedge clk); #1;
    set_stb = 1'b0;
    chdr.o_tready = 1'b0;
    for (int i = 1; i <= 6; i++) send(32'h7000_0000 + 32'(i), i == 6);
    drive_idle();
    n = 0;
    while (!chdr.o_tvalid && n < 50) begin @(posedge clk); #1; n++; end
    chdr.o_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chdr.o_tready = 1'b0;
    checks++; if (chdr.o_tvalid !== 1'b1 || chdr.o_tlast !== 1'b0) begin
      failures++; $display("FAIL pre_reset_data got valid=%b last=%b want valid=1 last=0", chdr.o_tvalid, chdr.o_tlast);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (chdr.o_tvalid !== 1'b0) begin failures++; $display("FAIL async_reset_tvalid got=%b want=0", chdr.o_tvalid); end
    checks++; if (seqnum !== 12'd0) begin failures++; $display("FAIL async_reset_seqnum got=%0d want=0", seqnum); end
    checks++; if (chdr.o_tdata !== 64'd0) begin failures++; $display("FAIL async_reset_tdata got=%h want=0", chdr.o_tdata); end
    exp_data_q.delete(); exp_last_q.delete();
    m_seq = 0; m_sid = 32'd0; m_maxlen = 364; m_count = 0; m_samps.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chdr.o_tready = 1'b1;
    send(32'h8000_0001, 1'b0);
    send(32'h8000_0002, 1'b1);
    drive_idle();
    wait_drain(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_reset_drain got=timeout want=drained"); end
    checks++; if (hdr_log[$] !== 64'h3000_0018_0000_0000) begin failures++; $display("FAIL post_reset_hdr got=%h want=3000001800000000", hdr_log[$]); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    run = 1'b1; strobe = 1'b0; eob = 1'b0; sample = '0; vita_time = '0;
    chdr.o_tready = 1'b1;
    m_count = 0; m_seq = 0; m_maxlen = 364; m_sid = 32'd0; m_time = '0;
    test_reset();
    test_basic();
    test_short_eob();
    test_maxlen_zero();
    test_sid_change();
    test_run_fall();
    test_overrun();
    test_clear();
    test_seq_wrap();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_sample_framer.md
# rx_sample_framer

Downstream neighbour of the RX control stage: accepts the DDC sample strobe qualified by `run`/`eob`, packs 32-bit samples into 64-bit lines, and emits timestamped CHDR data packets on an AXI-stream output. Supplies the `full`, `seqnum` and `sid` signals the RX control stage consumes for overrun detection and error-packet headers. Sits between the DDC/RX control pair and the RX packet mux.

## Interface
- `BASE`, 0: settings-bus base address (BASE = SID, BASE+1 = max samples per packet).
- `DATA_FIFO_SIZE`, 9: log2 depth (64-bit lines) of the sample buffer.
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of FIFOs, counters and seqnum.
- `set_stb`, `set_addr[7:0]`, `set_data[31:0]`  in  settings bus.
- `vita_time`  in  64  current time.
- `run`  in  1  RX control is streaming.
- `strobe`  in  1  sample valid.
- `eob`  in  1  last sample of burst (valid with `strobe`).
- `sample`  in  32  sample data.
- `full`  out  1  buffer cannot accept a sample this cycle.
- `seqnum`  out  12  sequence number of the next packet to be committed.
- `sid`  out  32  stream ID register.
- `o_tdata`  out  64; `o_tlast`  out  1; `o_tvalid`  out  1; `o_tready`  in  1  CHDR output.

## Operation
- Sample accepted when `strobe & run & ~full`. Even-indexed sample of a packet goes to `[63:32]` of a staging line, odd-indexed to `[31:0]`; line written to data FIFO on the odd sample or on packet close (low half zero-padded).
- `vita_time` captured on the first accepted sample of each packet.
- Packet closes on the accepted sample where count == maxlen, or `eob` = 1. Close pushes {flags, seqnum, len, time} into a header FIFO (16 entries); `seqnum` increments by 1, wrapping 4095 -> 0.
- Header word: `{flags[3:0], seqnum[11:0], len[15:0], sid[31:0]}`; flags = 4'h2 (data, has time), 4'h3 if EOB. `len` = 16 + 4*nsamps bytes.
- maxlen register (16 bits, reset 364): 0 treated as 1; values > 16376 clamped to 16376.
- Overrun: `strobe & run & full` discards the sample; an open partial packet (count > 0) is closed with EOB flag set. Nothing committed if count == 0.
- `run` falling with an open packet and no `eob`: packet closed with EOB flag on the falling-edge cycle.
- `full` = data-FIFO free space < 2 lines OR header FIFO has < 2 free entries.
- Output FSM: IDLE -> HDR (header FIFO non-empty) -> TIME -> DATA (ceil(nsamps/2) lines, `o_tlast` on last) -> IDLE. Each state advances only on `o_tvalid & o_tready`. Header entry popped on the last DATA beat.
- SID change mid-packet takes effect at next packet close (sampled at close).

## Timing
- Reset values: `full` 0, `seqnum` 0, `sid` 0, `o_tvalid` 0, `o_tlast` 0, `o_tdata` 0; FSM IDLE; FIFOs empty.
- `clear` has same effect as reset, one-cycle synchronous; packets in flight are dropped (no partial output).
- Header commit registered one cycle after the closing sample; HDR beat valid no earlier than 2 cycles after it.
- `full` is registered; updated the cycle after the write that changes it. The 2-line threshold covers the one-cycle lag.
- `o_tdata`/`o_tvalid` held stable while `o_tvalid & ~o_tready`.
- Simultaneous close and output pop in same cycle: both occur; header FIFO count unchanged.

## Structure
- Shared package: CHDR flag constants (DATA_TIME = 4'h2, DATA_TIME_EOB = 4'h3), header/time byte size (16), max-samples clamp (16376), settings offsets.
- Sub-modules: existing `axi_fifo` for the data buffer (64 bits, `DATA_FIFO_SIZE`) and `axi_fifo_short` for the header FIFO (108 bits: flags, seqnum, len, nsamps-lines, time, trimmed as needed). Packing/close logic and output FSM live in this module.

## Test plan
- maxlen=4, SID=0x00010002, 8 samples, eob on 8th -> two packets, headers 0x2000_0020_0001_0002 and 0x3001_0020_0001_0002, each 4 beats, time = vita_time at samples 1 and 5.
- maxlen=100, 3 samples eob -> len 28, flags 3, second data line low half 0, o_tlast on beat 4.
- Hold `o_tready`=0 until `full`=1, strobe once more -> sample dropped, open packet closed with EOB flag; released output drains all packets intact.
- Commit 4097 single-sample packets (maxlen=1) -> seqnum wraps 4095 -> 0 -> 1.
- `run` drops after 5 samples with no eob -> packet len 36, flags 3.
- Assert `reset` asynchronously mid-DATA beat -> `o_tvalid` 0 immediately, seqnum 0, subsequent packet starts fresh.
